// File: rtl/regfile_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regarb_pkg
// Purpose  : Shared widths and the requester id for the writeback arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package regarb_pkg;

  localparam int XLEN = 32;          // writeback data width
  localparam int AREG = 5;           // register address width
  localparam int NREG = 1 << AREG;   // architectural register count

  // Requester id; also the encoding of the round-robin priority pointer.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_t;

endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter_if
// Purpose  : Valid/ready writeback request bus for the ALU and LSU sources.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_write_arbiter_if;
  import regarb_pkg::*;

  logic            alu_valid;
  logic            alu_ready;
  logic [AREG-1:0] alu_addr;
  logic [XLEN-1:0] alu_data;

  logic            lsu_valid;
  logic            lsu_ready;
  logic [AREG-1:0] lsu_addr;
  logic [XLEN-1:0] lsu_data;

  // Requesters drive valid/addr/data and observe ready.
  modport master (
    output alu_valid, alu_addr, alu_data,
    input  alu_ready,
    output lsu_valid, lsu_addr, lsu_data,
    input  lsu_ready
  );

  // The arbiter consumes requests and returns ready.
  modport slave (
    input  alu_valid, alu_addr, alu_data,
    output alu_ready,
    input  lsu_valid, lsu_addr, lsu_data,
    output lsu_ready
  );

endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter_wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : wb_scoreboard
// Purpose  : Busy bits for registers with loads in flight; set wins over
//            clear, x0 never busy, lookups see the registered vector only.
// Revision : 1.0 - initial release
// ============================================================================
module wb_scoreboard
  import regarb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_set,
  input  logic [AREG-1:0] i_set_addr,
  input  logic            i_clr,
  input  logic [AREG-1:0] i_clr_addr,
  input  logic [AREG-1:0] i_rs1_addr,
  input  logic [AREG-1:0] i_rs2_addr,
  output logic            o_rs1_busy,
  output logic            o_rs2_busy,
  output logic [NREG-1:0] o_busy
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_next;

  // Apply clear first so a same-cycle set to the same register wins.
  always_comb begin
    w_busy_next = r_busy;
    if (i_clr) w_busy_next[i_clr_addr] = 1'b0;
    if (i_set) w_busy_next[i_set_addr] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_next;
  end

  assign o_busy     = r_busy;
  assign o_rs1_busy = r_busy[i_rs1_addr];
  assign o_rs2_busy = r_busy[i_rs2_addr];

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Round-robin arbitration of ALU and LSU writebacks onto the single
//            register-file write port, with a load busy scoreboard.
//            Optional macro REGARB_RVFI_EN adds registered rvfi_* outputs.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter
  import regarb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  regfile_write_arbiter_if.slave  wb_if,
  input  logic                    i_ld_issue,
  input  logic [AREG-1:0]         i_ld_issue_addr,
  input  logic [AREG-1:0]         i_rs1_addr,
  input  logic [AREG-1:0]         i_rs2_addr,
  output logic                    o_rs1_busy,
  output logic                    o_rs2_busy,
  output logic [NREG-1:0]         o_busy,
`ifdef REGARB_RVFI_EN
  output logic                    o_rvfi_valid,
  output logic [AREG-1:0]         o_rvfi_rd_addr,
  output logic [XLEN-1:0]         o_rvfi_rd_wdata,
`endif
  output logic                    o_rf_write,
  output logic [AREG-1:0]         o_rf_rd_addr,
  output logic [XLEN-1:0]         o_rf_rd
);

  req_id_t         r_prio;
  logic            w_alu_ready;
  logic            w_lsu_ready;
  logic            w_contend;
  logic            w_accept;
  logic [AREG-1:0] w_sel_addr;
  logic [XLEN-1:0] w_sel_data;

  // Grant: a lone requester always wins; under contention prio decides.
  // Ready is forced low while reset is held so nothing is consumed.
  always_comb begin
    w_contend   = wb_if.alu_valid & wb_if.lsu_valid;
    w_alu_ready = !rst && wb_if.alu_valid && (!wb_if.lsu_valid || r_prio == REQ_ALU);
    w_lsu_ready = !rst && wb_if.lsu_valid && (!wb_if.alu_valid || r_prio == REQ_LSU);
    w_accept    = w_alu_ready | w_lsu_ready;
    w_sel_addr  = w_lsu_ready ? wb_if.lsu_addr : wb_if.alu_addr;
    w_sel_data  = w_lsu_ready ? wb_if.lsu_data : wb_if.alu_data;
  end

  assign wb_if.alu_ready = w_alu_ready;
  assign wb_if.lsu_ready = w_lsu_ready;

  // Priority pointer moves to the loser after every contested cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_prio <= REQ_LSU;
    else if (w_contend) r_prio <= w_lsu_ready ? REQ_ALU : REQ_LSU;
  end

  // Registered write port; x0 updates addr/data but suppresses the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rf_write   <= 1'b0;
      o_rf_rd_addr <= '0;
      o_rf_rd      <= '0;
    end else begin
      o_rf_write <= w_accept && (w_sel_addr != '0);
      if (w_accept) begin
        o_rf_rd_addr <= w_sel_addr;
        o_rf_rd      <= w_sel_data;
      end
    end
  end

`ifdef REGARB_RVFI_EN
  // Retirement trace: every accepted request, x0 reported as zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rvfi_valid    <= 1'b0;
      o_rvfi_rd_addr  <= '0;
      o_rvfi_rd_wdata <= '0;
    end else begin
      o_rvfi_valid    <= w_accept;
      o_rvfi_rd_addr  <= (w_accept && w_sel_addr != '0) ? w_sel_addr : '0;
      o_rvfi_rd_wdata <= (w_accept && w_sel_addr != '0) ? w_sel_data : '0;
    end
  end
`endif

  wb_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .i_set      (i_ld_issue),
    .i_set_addr (i_ld_issue_addr),
    .i_clr      (w_lsu_ready),
    .i_clr_addr (wb_if.lsu_addr),
    .i_rs1_addr (i_rs1_addr),
    .i_rs2_addr (i_rs2_addr),
    .o_rs1_busy (o_rs1_busy),
    .o_rs2_busy (o_rs2_busy),
    .o_busy     (o_busy)
  );

endmodule
`default_nettype wire
